// File: rtl/eth_rx_frame_buffer_if.sv
// MAC receive stream plus CPU register-window bus for eth_rx_frame_buffer.
// master = MAC/CPU side driving the block, slave = the frame buffer.
interface eth_rx_frame_buffer_if;
    logic [7:0]  rx_axis_mac_tdata;
    logic        rx_axis_mac_tvalid;
    logic        rx_axis_mac_tlast;
    logic        rx_axis_mac_tuser;
    logic [3:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        irq;

    modport master (
        output rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, irq
    );

    modport slave (
        input  rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, irq
    );
endinterface

// File: rtl/eth_rx_frame_buffer.sv
// Receive frame buffer: captures good MAC frames into a circular byte RAM and exposes them to the CPU.
// Optional dropped-frame counter is built only when ETH_RX_DROPCNT_EN is defined.
module eth_rx_frame_buffer #(
    parameter int ADDR_W     = 11,
    parameter int LEN_FIFO_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_rx_frame_buffer_if.slave bus
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [ADDR_W:0]     PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]     PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_FIFO_W:0] FIFO_ONE  = {{LEN_FIFO_W{1'b0}}, 1'b1};
    localparam logic [LEN_FIFO_W:0] FIFO_FULL = {1'b1, {LEN_FIFO_W{1'b0}}};

    logic [7:0]          ram_r [0:(2**ADDR_W)-1];
    logic [ADDR_W:0]     len_fifo_r [0:(2**LEN_FIFO_W)-1];

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [ADDR_W:0]     wr_ptr_r;
    logic [ADDR_W:0]     commit_ptr_r;
    logic [ADDR_W:0]     rd_ptr_r;
    logic [ADDR_W:0]     idx_r;
    logic [LEN_FIFO_W:0] fifo_wr_r;
    logic [LEN_FIFO_W:0] fifo_rd_r;
    logic [31:0]         rdata_r;
    logic                irq_r;

    logic [ADDR_W:0]     wr_ptr_nxt_s;
    logic [ADDR_W:0]     commit_ptr_nxt_s;
    logic [ADDR_W:0]     wr_inc_s;
    logic [ADDR_W:0]     push_len_s;
    logic                ram_we_s;
    logic                push_s;
    logic                drop_s;
    logic                buf_full_s;
    logic [LEN_FIFO_W:0] fifo_cnt_s;
    logic [LEN_FIFO_W:0] fifo_wr_nxt_s;
    logic [LEN_FIFO_W:0] fifo_rd_nxt_s;
    logic                fifo_full_s;
    logic                frame_avail_s;
    logic [ADDR_W:0]     head_len_s;
    logic [1:0]          reg_sel_s;
    logic                data_adv_s;
    logic                release_s;
    logic [31:0]         status_s;
    logic [15:0]         dropcnt_s;
    logic                unused_s;

    assign wr_inc_s      = wr_ptr_r + PTR_ONE;
    assign push_len_s    = wr_inc_s - commit_ptr_r;
    assign buf_full_s    = ((wr_ptr_r - rd_ptr_r) == PTR_FULL);
    assign fifo_cnt_s    = fifo_wr_r - fifo_rd_r;
    assign fifo_full_s   = (fifo_cnt_s == FIFO_FULL);
    assign frame_avail_s = (fifo_cnt_s != {(LEN_FIFO_W+1){1'b0}});
    assign head_len_s    = frame_avail_s ? len_fifo_r[fifo_rd_r[LEN_FIFO_W-1:0]] : {(ADDR_W+1){1'b0}};
    assign reg_sel_s     = bus.mem_addr[3:2];

    // A DATA read only advances inside the head frame, so uncommitted bytes are never visible.
    assign data_adv_s    = bus.mem_rd && (reg_sel_s == 2'd1) && (idx_r < head_len_s);
    assign release_s     = bus.mem_wr && (reg_sel_s == 2'd2) && bus.mem_wdata[0] && frame_avail_s;

    assign fifo_wr_nxt_s = push_s    ? (fifo_wr_r + FIFO_ONE) : fifo_wr_r;
    assign fifo_rd_nxt_s = release_s ? (fifo_rd_r + FIFO_ONE) : fifo_rd_r;

    assign status_s = {frame_avail_s, 3'b000, 4'(fifo_cnt_s), 8'h00, 16'(head_len_s)};

    // Receive FSM: decides RAM write, pointer moves, commit and drop for the current beat.
    always_comb begin
        state_nxt_s      = state_r;
        wr_ptr_nxt_s     = wr_ptr_r;
        commit_ptr_nxt_s = commit_ptr_r;
        ram_we_s         = 1'b0;
        push_s           = 1'b0;
        drop_s           = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (bus.rx_axis_mac_tvalid && bus.rx_axis_mac_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_IDLE, ST_RECV: begin
                if (bus.rx_axis_mac_tvalid) begin
                    if (buf_full_s) begin
                        // A full buffer on the final beat is dropped right away instead of via DROP.
                        if (bus.rx_axis_mac_tlast) begin
                            wr_ptr_nxt_s = commit_ptr_r;
                            drop_s       = 1'b1;
                            state_nxt_s  = ST_IDLE;
                        end else begin
                            state_nxt_s  = ST_DROP;
                        end
                    end else begin
                        ram_we_s     = 1'b1;
                        wr_ptr_nxt_s = wr_inc_s;
                        if (bus.rx_axis_mac_tlast) begin
                            if (!bus.rx_axis_mac_tuser && !fifo_full_s) begin
                                push_s           = 1'b1;
                                commit_ptr_nxt_s = wr_inc_s;
                            end else begin
                                wr_ptr_nxt_s = commit_ptr_r;
                                drop_s       = 1'b1;
                            end
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_RECV;
                        end
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DROP: begin
                if (bus.rx_axis_mac_tvalid && bus.rx_axis_mac_tlast) begin
                    wr_ptr_nxt_s = commit_ptr_r;
                    drop_s       = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s  = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_SYNC;
            end
        endcase
    end

    // Receive-side state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_SYNC;
            wr_ptr_r     <= {(ADDR_W+1){1'b0}};
            commit_ptr_r <= {(ADDR_W+1){1'b0}};
            fifo_wr_r    <= {(LEN_FIFO_W+1){1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            commit_ptr_r <= commit_ptr_nxt_s;
            fifo_wr_r    <= fifo_wr_nxt_s;
        end
    end

    // Frame byte storage; written at the current write pointer.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[wr_ptr_r[ADDR_W-1:0]] <= bus.rx_axis_mac_tdata;
        end
    end

    // Committed frame lengths; emptiness is tracked by the reset pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            len_fifo_r[fifo_wr_r[LEN_FIFO_W-1:0]] <= push_len_s;
        end
    end

    // CPU read side: release skips the rest of the head frame, DATA reads step through it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= {(ADDR_W+1){1'b0}};
            idx_r     <= {(ADDR_W+1){1'b0}};
            fifo_rd_r <= {(LEN_FIFO_W+1){1'b0}};
        end else if (release_s) begin
            rd_ptr_r  <= rd_ptr_r - idx_r + head_len_s;
            idx_r     <= {(ADDR_W+1){1'b0}};
            fifo_rd_r <= fifo_rd_nxt_s;
        end else if (data_adv_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            idx_r     <= idx_r + PTR_ONE;
        end
    end

`ifdef ETH_RX_DROPCNT_EN
    logic [15:0] dropcnt_r;
    logic        clr_s;

    assign clr_s     = bus.mem_wr && (reg_sel_s == 2'd3);
    assign dropcnt_s = dropcnt_r;
    assign unused_s  = ^{bus.mem_wdata[31:1], bus.mem_addr[1:0]};

    // Saturating drop counter; a clear in the same cycle as a drop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropcnt_r <= 16'h0000;
        end else if (clr_s) begin
            dropcnt_r <= 16'h0000;
        end else if (drop_s && (dropcnt_r != 16'hFFFF)) begin
            dropcnt_r <= dropcnt_r + 16'h0001;
        end
    end
`else
    assign dropcnt_s = 16'h0000;
    assign unused_s  = ^{bus.mem_wdata[31:1], bus.mem_addr[1:0], drop_s};
`endif

    // Registered read data and interrupt level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
            irq_r   <= 1'b0;
        end else begin
            irq_r <= (fifo_wr_nxt_s != fifo_rd_nxt_s);
            if (bus.mem_rd) begin
                case (reg_sel_s)
                    2'd0:    rdata_r <= status_s;
                    2'd1:    rdata_r <= data_adv_s ? {24'h00_0000, ram_r[rd_ptr_r[ADDR_W-1:0]]} : 32'h0000_0000;
                    2'd3:    rdata_r <= {16'h0000, dropcnt_s};
                    default: rdata_r <= 32'h0000_0000;
                endcase
            end
        end
    end

    assign bus.mem_rdata = rdata_r;
    assign bus.irq       = irq_r;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Directed bench for eth_rx_frame_buffer: one default-size instance and one with a 64-byte RAM.
module tb_eth_rx_frame_buffer;

`ifdef ETH_RX_DROPCNT_EN
    localparam logic [31:0] DROP_ONE = 32'd1;
`else
    localparam logic [31:0] DROP_ONE = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] d;
    int          checks;
    int          failures;

    eth_rx_frame_buffer_if bus_big ();
    eth_rx_frame_buffer_if bus_small ();

    assign bus_big.rx_axis_mac_tdata    = tdata;
    assign bus_big.rx_axis_mac_tvalid   = tvalid & ~sel;
    assign bus_big.rx_axis_mac_tlast    = tlast;
    assign bus_big.rx_axis_mac_tuser    = tuser;
    assign bus_big.mem_addr             = addr;
    assign bus_big.mem_rd               = rd & ~sel;
    assign bus_big.mem_wr               = wr & ~sel;
    assign bus_big.mem_wdata            = wdata;

    assign bus_small.rx_axis_mac_tdata  = tdata;
    assign bus_small.rx_axis_mac_tvalid = tvalid & sel;
    assign bus_small.rx_axis_mac_tlast  = tlast;
    assign bus_small.rx_axis_mac_tuser  = tuser;
    assign bus_small.mem_addr           = addr;
    assign bus_small.mem_rd             = rd & sel;
    assign bus_small.mem_wr             = wr & sel;
    assign bus_small.mem_wdata          = wdata;

    assign rdata = sel ? bus_small.mem_rdata : bus_big.mem_rdata;
    assign irq   = sel ? bus_small.irq : bus_big.irq;

    eth_rx_frame_buffer #(.ADDR_W(11), .LEN_FIFO_W(2)) dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_big)
    );

    eth_rx_frame_buffer #(.ADDR_W(6), .LEN_FIFO_W(2)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic bad);
        for (int i = 0; i < len; i++) begin
            tdata  = base + 8'(i);
            tvalid = 1'b1;
            tlast  = (i == len - 1);
            tuser  = bad && (i == len - 1);
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
        addr = a;
        rd   = 1'b1;
        @(posedge clk); #1;
        rd   = 1'b0;
        v    = rdata;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        wr    = 1'b1;
        @(posedge clk); #1;
        wr    = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        sel = 1'b0; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        addr = 4'h0; rd = 1'b0; wr = 1'b0; wdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A lone end-of-frame beat lets the block leave SYNC; nothing is captured.
        send_frame(1, 8'hEE, 1'b0);
        read_reg(4'h0, d); chk("status_after_sync", d, 32'h0);

        // 64-byte good frame.
        send_frame(64, 8'h00, 1'b0);
        chk("irq_64", 32'(irq), 32'h1);
        read_reg(4'h0, d); chk("status_64", d, 32'h8100_0040);
        for (int i = 0; i < 64; i++) begin
            read_reg(4'h4, d); chk("data_64", d, 32'(i));
        end
        read_reg(4'h4, d); chk("data_65th", d, 32'h0);
        write_reg(4'h8, 32'h1);
        read_reg(4'h0, d); chk("status_released", d, 32'h0);
        chk("irq_released", 32'(irq), 32'h0);
        read_reg(4'h4, d); chk("data_noframe", d, 32'h0);
        read_reg(4'h8, d); chk("ctrl_read_zero", d, 32'h0);

        // Bad frame then good 10-byte frame.
        send_frame(60, 8'h20, 1'b1);
        send_frame(10, 8'hA0, 1'b0);
        read_reg(4'h0, d); chk("status_10", d, 32'h8100_000A);
        read_reg(4'h4, d); chk("data_10_first", d, 32'h0000_00A0);
        read_reg(4'hC, d); chk("dropcnt_bad", d, DROP_ONE);
        write_reg(4'hC, 32'h0);
        read_reg(4'hC, d); chk("dropcnt_cleared", d, 32'h0);
        write_reg(4'h0, 32'hFFFF_FFFF);
        read_reg(4'h0, d); chk("status_ro", d, 32'h8100_000A);
        write_reg(4'h8, 32'h1);
        read_reg(4'h0, d); chk("status_10_rel", d, 32'h0);

        // Reset while a frame is queued, released mid-frame; only the following frame is kept.
        send_frame(5, 8'h30, 1'b0);
        apply_reset();
        read_reg(4'h0, d); chk("status_after_rst", d, 32'h0);
        send_frame(7, 8'h55, 1'b0);
        send_frame(16, 8'h60, 1'b0);
        read_reg(4'h0, d); chk("status_16", d, 32'h8100_0010);
        read_reg(4'h4, d); chk("data_16_first", d, 32'h0000_0060);
        chk("wr_ptr_16", 32'(dut_big.wr_ptr_r), 32'd16);
        write_reg(4'h8, 32'h1);

        // Five 8-byte frames, four-entry length FIFO: the fifth is dropped.
        for (int f = 0; f < 5; f++) begin
            send_frame(8, 8'(8'h80 + 8'(f * 8)), 1'b0);
        end
        read_reg(4'h0, d); chk("status_five", d, 32'h8400_0008);
        chk("wr_ptr_five", 32'(dut_big.wr_ptr_r), 32'd48);
        read_reg(4'hC, d); chk("dropcnt_five", d, DROP_ONE);
        for (int f = 0; f < 4; f++) begin
            write_reg(4'h8, 32'h1);
        end
        read_reg(4'h0, d); chk("status_five_rel", d, 32'h0);

        // Commit of a 12-byte frame on the same edge as release of the 20-byte head.
        send_frame(20, 8'h40, 1'b0);
        read_reg(4'h0, d); chk("status_20", d, 32'h8100_0014);
        for (int i = 0; i < 12; i++) begin
            tdata  = 8'h90 + 8'(i);
            tvalid = 1'b1;
            tlast  = (i == 11);
            if (i == 11) begin
                addr = 4'h8; wdata = 32'h1; wr = 1'b1;
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0; wr = 1'b0;
        read_reg(4'h0, d); chk("status_commit_rel", d, 32'h8100_000C);
        for (int i = 0; i < 12; i++) begin
            read_reg(4'h4, d); chk("data_12", d, 32'h90 + 32'(i));
        end
        read_reg(4'h4, d); chk("data_12_end", d, 32'h0);

        // Small instance: 64-byte RAM overflow, then a frame wrapping the RAM end.
        sel = 1'b1;
        send_frame(1, 8'hEE, 1'b0);
        send_frame(40, 8'h00, 1'b0);
        read_reg(4'h0, d); chk("small_status_40", d, 32'h8100_0028);
        send_frame(30, 8'h50, 1'b0);
        read_reg(4'h0, d); chk("small_status_ovf", d, 32'h8100_0028);
        read_reg(4'hC, d); chk("small_dropcnt", d, DROP_ONE);
        write_reg(4'h8, 32'h1);
        chk("small_irq_rel", 32'(irq), 32'h0);
        send_frame(50, 8'h10, 1'b0);
        read_reg(4'h0, d); chk("small_status_50", d, 32'h8100_0032);
        chk("small_irq_50", 32'(irq), 32'h1);
        for (int i = 0; i < 50; i++) begin
            read_reg(4'h4, d); chk("small_data_wrap", d, 32'h10 + 32'(i));
        end
        read_reg(4'h4, d); chk("small_data_end", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
